mux_2to1_1b: RTL and testbench



---
 rtl/mux_2to1_1b.sv | 51 +++++
 tb/tb_mux_2to1_1b.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mux_2to1_1b.sv
`default_nettype none
// ============================================================================
//  Module   : mux_2to1_1b
//  Purpose  : Single-bit 2-to-1 multiplexer with a registered output. This is
//             the bit-select primitive of the 8-bit CPU datapath; wider muxes
//             are built by instantiating it once per bit.
//
//  Ports    : input_a        in   1  data, selected when input_select = 0
//             input_b        in   1  data, selected when input_select = 1
//             input_select   in   1  select line (0 -> a, 1 -> b)
//             output_result  out  1  registered mux result (1-cycle latency)
//             clk            in   1  rising-edge clock
//             rst_n          in   1  synchronous reset, active-low
//
//  Revision : 1.0  initial release
// ============================================================================
module mux_2to1_1b (
   input  logic input_a,
   input  logic input_b,
   input  logic input_select,
   output logic output_result,
   input  logic clk,
   input  logic rst_n
);

   localparam logic C_RESET_VALUE = 1'b0;

   logic result_d;
   logic result_q;

   // The conditional operator is kept deliberately: with an unknown select it
   // yields the common value when both data inputs agree, X otherwise.
   always_comb begin
      result_d = input_select ? input_b : input_a;
   end

   // Reset is only sampled on the clock edge and wins over any data change
   // arriving at the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= C_RESET_VALUE;
      end else begin
         result_q <= result_d;
      end
   end

   // Output comes straight from the flop; no input reaches it combinationally.
   assign output_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_2to1_1b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_2to1_1b
//  Purpose  : Directed self-checking bench for mux_2to1_1b. Inputs change on
//             the falling edge; the output is sampled 1 time unit after each
//             rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_2to1_1b;

   logic clk;
   logic rst_n;
   logic input_a;
   logic input_b;
   logic input_select;
   logic output_result;

   int   errors;
   int   checks;

   logic [7:0] tt_expected;

   mux_2to1_1b dut (
      .input_a       (input_a),
      .input_b       (input_b),
      .input_select  (input_select),
      .output_result (output_result),
      .clk           (clk),
      .rst_n         (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic expected);
      checks++;
      assert (output_result === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, output_result, expected);
      end
   endtask

   // Drive a full input vector on the falling edge, then advance to just
   // after the next rising edge.
   task automatic drive_and_clock(input logic a, input logic b, input logic sel,
                                  input logic rn);
      @(negedge clk);
      input_a      = a;
      input_b      = b;
      input_select = sel;
      rst_n        = rn;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      tt_expected  = 8'b1100_1010;   // bit i = next for {sel,b,a} = i
      rst_n        = 1'b0;
      input_a      = 1'b1;
      input_b      = 1'b1;
      input_select = 1'b1;

      // Reset held for two edges with a data path that would otherwise give 1.
      drive_and_clock(1'b1, 1'b1, 1'b1, 1'b0);
      check("reset_edge1", 1'b0);
      drive_and_clock(1'b1, 1'b1, 1'b1, 1'b0);
      check("reset_edge2", 1'b0);

      // Release: first edge sampled high loads next (= b = 1).
      drive_and_clock(1'b1, 1'b1, 1'b1, 1'b1);
      check("reset_release", 1'b1);

      // Exhaustive truth table, a toggling fastest.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         drive_and_clock(v[0], v[1], v[2], 1'b1);
         check($sformatf("truth_%0d", i), tt_expected[i]);
      end

      // Select toggling with a=1, b=0.
      for (int i = 0; i < 6; i++) begin
         logic s;
         s = (i % 2 == 1);
         drive_and_clock(1'b1, 1'b0, s, 1'b1);
         check($sformatf("sel_toggle_%0d", i), ~s);
      end

      // Glitch immunity: establish output 0, then pulse sel between edges.
      drive_and_clock(1'b0, 1'b1, 1'b0, 1'b1);
      check("glitch_setup", 1'b0);
      #2 input_select = 1'b1;
      #2 input_select = 1'b0;
      @(posedge clk);
      #1;
      check("glitch_hold", 1'b0);

      // Reset pulsed low between edges must not clear the output.
      drive_and_clock(1'b1, 1'b0, 1'b0, 1'b1);
      check("pre_reset_glitch", 1'b1);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_between_edges", 1'b1);

      // Reset mid-stream overrides data, then data resumes.
      drive_and_clock(1'b1, 1'b0, 1'b0, 1'b0);
      check("midstream_reset", 1'b0);
      drive_and_clock(1'b1, 1'b0, 1'b0, 1'b1);
      check("midstream_release", 1'b1);

      // Unknown select: agreeing data inputs give a defined result.
      drive_and_clock(1'b1, 1'b1, 1'bx, 1'b1);
      check("xsel_both_one", 1'b1);
      drive_and_clock(1'b0, 1'b0, 1'bx, 1'b1);
      check("xsel_both_zero", 1'b0);
      // With a != b the result is X in a four-state simulator; two-state
      // simulators resolve the select arbitrarily, so it is left unchecked.
      drive_and_clock(1'b0, 1'b1, 1'bx, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
